// File: rtl/obstacle_sched_pkg.sv
// Shared types and default constants for the cactus obstacle spawn scheduler.
package obstacle_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    PICK,
    REQ
  } sched_state_t;

  localparam int NSLOT_DEF     = 2;
  localparam int MIN_GAP_DEF   = 40;
  localparam int GAP_FLOOR_DEF = 16;
  localparam int GAP_W_DEF     = 8;
  localparam int TYPE_W        = 3;
  localparam int RATE_W        = 4;
  localparam int RAND_W        = 5;
  localparam int CNT_W         = 8;

endpackage

// File: rtl/obstacle_sched_if.sv
// Spawn channel between the scheduler (master) and the cactus renderers (slave).
interface obstacle_sched_if
  import obstacle_sched_pkg::*;
#(
  parameter int NSLOT = NSLOT_DEF
) ();

  logic              spawn_valid;
  logic [NSLOT-1:0]  spawn_slot;
  logic [TYPE_W-1:0] spawn_type;
  logic [NSLOT-1:0]  spawn_ready;
  logic [NSLOT-1:0]  slot_busy;

  modport master (
    output spawn_valid, spawn_slot, spawn_type,
    input  spawn_ready, slot_busy
  );

  modport slave (
    input  spawn_valid, spawn_slot, spawn_type,
    output spawn_ready, slot_busy
  );

endinterface

// File: rtl/obstacle_sched_rr_pick.sv
// Round-robin free-slot finder: first non-busy slot searching from ptr+1 with wrap.
module obstacle_sched_rr_pick #(
  parameter  int NSLOT = 2,
  localparam int IDX_W = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
  input  logic [NSLOT-1:0] busy,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx,
  output logic [NSLOT-1:0] onehot
);

  logic [IDX_W-1:0] cand;

  // NOTE: every output gets a default before the loop so no path leaves a value held (no latch).
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    cand   = '0;
    for (int k = 1; k <= NSLOT; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NSLOT);
      if (!found && !busy[cand]) begin
        found        = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/obstacle_sched.sv
// Obstacle spawn scheduler: frame-counted gap, round-robin slot pick, valid/ready spawn.
module obstacle_sched
  import obstacle_sched_pkg::*;
#(
  parameter int NSLOT     = NSLOT_DEF,
  parameter int MIN_GAP   = MIN_GAP_DEF,
  parameter int GAP_FLOOR = GAP_FLOOR_DEF,
  parameter int GAP_W     = GAP_W_DEF
) (
  input  logic              lcd_pclk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic              is_living,
  input  logic [RATE_W-1:0] move_rate,
  input  logic [RAND_W-1:0] random_five,
  input  logic [TYPE_W-1:0] random_three,
  obstacle_sched_if.master  sp,
  output logic [CNT_W-1:0]  spawn_count
);

  localparam int IDX_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int GW    = GAP_W + 1;

  sched_state_t      state;
  logic              living_q;
  logic [GAP_W-1:0]  gap_cnt;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  pick_idx;
  logic              valid_r;
  logic [NSLOT-1:0]  slot_r;
  logic [TYPE_W-1:0] type_r;

  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx_c;
  logic [NSLOT-1:0]  pick_onehot;
  logic              handshake;
  logic [GAP_W:0]    gap_raw;
  logic [GAP_W-1:0]  gap_load;

  obstacle_sched_rr_pick #(.NSLOT(NSLOT)) u_rr_pick (
    .busy   (sp.slot_busy),
    .ptr    (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx_c),
    .onehot (pick_onehot)
  );

  // One extra bit lets a high speed push the raw gap negative before clamping to the floor.
  always_comb begin
    gap_raw = GW'(MIN_GAP) + GW'(random_five) - (GW'(move_rate) << 1);
    if ($signed(gap_raw) < $signed(GW'(GAP_FLOOR))) gap_load = GAP_W'(GAP_FLOOR);
    else                                            gap_load = gap_raw[GAP_W-1:0];
  end

  assign handshake = |(slot_r & sp.spawn_ready);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      state       <= IDLE;
      living_q    <= 1'b0;
      gap_cnt     <= '0;
      rr_ptr      <= IDX_W'(NSLOT - 1);
      pick_idx    <= '0;
      valid_r     <= 1'b0;
      slot_r      <= '0;
      type_r      <= '0;
      spawn_count <= '0;
    end else begin
      living_q <= is_living;
      if (!is_living) begin
        // Abort beats a same-cycle handshake; the tally stays frozen for display.
        state   <= IDLE;
        gap_cnt <= '0;
        valid_r <= 1'b0;
        slot_r  <= '0;
        type_r  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (!living_q) begin
              spawn_count <= '0;
              gap_cnt     <= gap_load;
              state       <= GAP;
            end
          end
          GAP: begin
            if (frame_tick && gap_cnt != '0) begin
              gap_cnt <= gap_cnt - 1'b1;
              if (gap_cnt == GAP_W'(1)) state <= PICK;
            end
          end
          PICK: begin
            if (pick_found) begin
              slot_r   <= pick_onehot;
              type_r   <= random_three;
              pick_idx <= pick_idx_c;
              valid_r  <= 1'b1;
              state    <= REQ;
            end
          end
          REQ: begin
            if (handshake) begin
              valid_r <= 1'b0;
              slot_r  <= '0;
              type_r  <= '0;
              rr_ptr  <= pick_idx;
              if (spawn_count != '1) spawn_count <= spawn_count + 1'b1;
              gap_cnt <= gap_load;
              state   <= GAP;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign sp.spawn_valid = valid_r;
  assign sp.spawn_slot  = slot_r;
  assign sp.spawn_type  = type_r;

endmodule
